// File: rtl/wb_stage.sv
// Write-back stage: arbitrates the register-file write port between the MEM/WB result and a
// small FIFO of long-latency results. Optional same-cycle bypass outputs under WB_FWD_EN.
module wb_stage #(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        is_stalling,
  input  logic        mem_valid_i,
  output logic        mem_ready_o,
  input  logic        mem_reg_write_i,
  input  logic [4:0]  mem_dst_i,
  input  logic        mem_to_reg_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] load_data_i,
  input  logic [2:0]  load_op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        lu_valid_i,
  output logic        lu_ready_o,
  input  logic [4:0]  lu_dst_i,
  input  logic [31:0] lu_data_i,
  output logic        starve_stall_o,
`ifdef WB_FWD_EN
  output logic        fwd_valid_o,
  output logic [4:0]  fwd_id_o,
  output logic [31:0] fwd_data_o,
`endif
  output logic        reg_write_o,
  output logic [4:0]  reg_write_id_o,
  output logic [31:0] reg_write_data_o
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned StvW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]      fifo_dst_q  [FIFO_DEPTH];
  logic [31:0]     fifo_data_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [StvW-1:0] starve_cnt_q, starve_cnt_d;

  logic        active, head_valid, push, pop, pipe_cand;
  logic        sel_valid;
  logic [4:0]  sel_id, head_dst;
  logic [31:0] sel_data, pipe_data, head_data;

  logic        reg_write_q;
  logic [4:0]  reg_write_id_q;
  logic [31:0] reg_write_data_q;

  function automatic logic [31:0] extract_load(input logic [2:0]  op,
                                               input logic [1:0]  lo,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = 8'(word >> {lo, 3'b000});
    h = lo[1] ? word[31:16] : word[15:0];
    case (op)
      3'b000:  res = {{24{b[7]}}, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b100:  res = {24'h0, b};
      3'b101:  res = {16'h0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  assign active         = !is_stalling;
  assign head_valid     = (count_q != '0);
  assign head_dst       = fifo_dst_q[rd_ptr_q];
  assign head_data      = fifo_data_q[rd_ptr_q];
  assign lu_ready_o     = (count_q != CntW'(FIFO_DEPTH));
  assign push           = lu_valid_i & lu_ready_o;
  assign starve_stall_o = (starve_cnt_q == StvW'(STARVE_LIMIT));
  assign mem_ready_o    = active & !starve_stall_o;
  assign pipe_cand      = mem_valid_i & mem_reg_write_i & (mem_dst_i != 5'd0);
  assign pipe_data      = mem_to_reg_i ? extract_load(load_op_i, addr_lo_i, load_data_i)
                                       : alu_result_i;

  // A forced drain always has a head: the counter only advances while the FIFO is non-empty.
  always_comb begin
    pop          = 1'b0;
    sel_valid    = 1'b0;
    sel_id       = mem_dst_i;
    sel_data     = pipe_data;
    starve_cnt_d = starve_cnt_q;
    if (active) begin
      if (starve_stall_o) begin
        pop = head_valid;
      end else if (pipe_cand) begin
        sel_valid = 1'b1;
      end else begin
        pop = head_valid;
      end

      if (pop) begin
        sel_valid    = (head_dst != 5'd0);
        sel_id       = head_dst;
        sel_data     = head_data;
        starve_cnt_d = '0;
      end else if (head_valid && pipe_cand) begin
        starve_cnt_d = starve_cnt_q + StvW'(1);
      end else begin
        starve_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) begin
      fifo_dst_q[wr_ptr_q]  <= lu_dst_i;
      fifo_data_q[wr_ptr_q] <= lu_data_i;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Id/data hold their last value on idle cycles; everything holds during a stall.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      reg_write_q      <= 1'b0;
      reg_write_id_q   <= 5'd0;
      reg_write_data_q <= 32'd0;
    end else if (active) begin
      reg_write_q <= sel_valid;
      if (sel_valid) begin
        reg_write_id_q   <= sel_id;
        reg_write_data_q <= sel_data;
      end
    end
  end

  assign reg_write_o      = reg_write_q;
  assign reg_write_id_o   = reg_write_id_q;
  assign reg_write_data_o = reg_write_data_q;

`ifdef WB_FWD_EN
  assign fwd_valid_o = active & sel_valid;
  assign fwd_id_o    = sel_id;
  assign fwd_data_o  = sel_data;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a queue-based reference model checked every cycle, plus
// hand-computed literal checks along the stimulus.
module tb_wb_stage;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned LIMIT = 4;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        is_stalling = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_reg_write = 1'b0;
  logic [4:0]  mem_dst = '0;
  logic        mem_to_reg = 1'b0;
  logic [31:0] alu = '0;
  logic [31:0] load_data = '0;
  logic [2:0]  load_op = '0;
  logic [1:0]  addr_lo = '0;
  logic        lu_valid = 1'b0;
  logic [4:0]  lu_dst = '0;
  logic [31:0] lu_data = '0;

  logic        mem_ready, lu_ready, starve, rw;
  logic [4:0]  rw_id;
  logic [31:0] rw_data;
`ifdef WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_id;
  logic [31:0] fwd_data;
`endif

  int total = 0;
  int bad = 0;

  wb_stage #(
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .sys_clk          (sys_clk),
    .rst_n            (rst_n),
    .is_stalling      (is_stalling),
    .mem_valid_i      (mem_valid),
    .mem_ready_o      (mem_ready),
    .mem_reg_write_i  (mem_reg_write),
    .mem_dst_i        (mem_dst),
    .mem_to_reg_i     (mem_to_reg),
    .alu_result_i     (alu),
    .load_data_i      (load_data),
    .load_op_i        (load_op),
    .addr_lo_i        (addr_lo),
    .lu_valid_i       (lu_valid),
    .lu_ready_o       (lu_ready),
    .lu_dst_i         (lu_dst),
    .lu_data_i        (lu_data),
    .starve_stall_o   (starve),
`ifdef WB_FWD_EN
    .fwd_valid_o      (fwd_valid),
    .fwd_id_o         (fwd_id),
    .fwd_data_o       (fwd_data),
`endif
    .reg_write_o      (rw),
    .reg_write_id_o   (rw_id),
    .reg_write_data_o (rw_data)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  d;
    logic [31:0] v;
  } ent_t;

  ent_t        q[$];
  int          lost = 0;
  bit          m_we = 0;
  logic [4:0]  m_id = '0;
  logic [31:0] m_data = '0;
  bit          model_ok = 0;

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] lo,
                                           input logic [31:0] w);
    int v;
    int sh;
    if (op == 3'd0 || op == 3'd4) begin
      sh = 8 * int'(lo);
      v  = int'((w >> sh) & 32'hff);
      if (op == 3'd0 && v > 127) v -= 256;
    end else if (op == 3'd1 || op == 3'd5) begin
      sh = lo[1] ? 16 : 0;
      v  = int'((w >> sh) & 32'hffff);
      if (op == 3'd1 && v > 32767) v -= 65536;
    end else begin
      return w;
    end
    return 32'(v);
  endfunction

  // Advance the model to the state just after the coming posedge.
  function automatic void model_step();
    bit   push;
    bit   pipe;
    ent_t h;
    if (!rst_n) begin
      q.delete();
      lost     = 0;
      m_we     = 0;
      m_id     = '0;
      m_data   = '0;
      model_ok = 1;
      return;
    end
    if (!model_ok) return;
    push = lu_valid && (q.size() < DEPTH);
    if (!is_stalling) begin
      pipe = mem_valid && mem_reg_write && (mem_dst != 0);
      m_we = 0;
      if ((lost == LIMIT) || (!pipe && q.size() > 0)) begin
        h    = q.pop_front();
        lost = 0;
        if (h.d != 0) begin
          m_we   = 1;
          m_id   = h.d;
          m_data = h.v;
        end
      end else if (pipe) begin
        m_we   = 1;
        m_id   = mem_dst;
        m_data = mem_to_reg ? ref_load(load_op, addr_lo, load_data) : alu;
        lost   = (q.size() > 0) ? lost + 1 : 0;
      end else begin
        lost = 0;
      end
    end
    if (push) q.push_back('{lu_dst, lu_data});
  endfunction

  always @(negedge sys_clk) begin
    if (model_ok) begin
      chk("m_reg_write", 32'(rw), 32'(m_we));
      chk("m_reg_id", 32'(rw_id), 32'(m_id));
      chk("m_reg_data", rw_data, m_data);
      chk("m_starve", 32'(starve), 32'(lost == LIMIT));
      chk("m_lu_ready", 32'(lu_ready), 32'(q.size() < DEPTH));
      chk("m_mem_ready", 32'(mem_ready), 32'(!is_stalling && lost != LIMIT));
    end
    model_step();
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic pipe_set(input bit v, input bit wr, input logic [4:0] d, input bit m2r,
                          input logic [31:0] a, input logic [31:0] ld,
                          input logic [2:0] op, input logic [1:0] lo);
    mem_valid     = v;
    mem_reg_write = wr;
    mem_dst       = d;
    mem_to_reg    = m2r;
    alu           = a;
    load_data     = ld;
    load_op       = op;
    addr_lo       = lo;
  endtask

  // Hold lu_valid until accepted; n = edges spent including the accepting one.
  task automatic lu_push(input logic [4:0] d, input logic [31:0] v, output int n);
    bit r;
    lu_valid = 1'b1;
    lu_dst   = d;
    lu_data  = v;
    n        = 0;
    r        = 1'b0;
    forever begin
      r = lu_ready;
      cyc();
      n++;
      if (r || n >= 20) break;
    end
    lu_valid = 1'b0;
    if (!r) begin
      total++;
      bad++;
      $display("FAIL lu_push_timeout: got no accept expected accept within 20 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    cyc();
    cyc();
    chk("rst_reg_write", 32'(rw), 32'd0);
    chk("rst_reg_data", rw_data, 32'd0);
    chk("rst_lu_ready", 32'(lu_ready), 32'd1);
    chk("rst_mem_ready", 32'(mem_ready), 32'd1);
    chk("rst_starve", 32'(starve), 32'd0);
    rst_n = 1'b1;

    // Load extraction
    pipe_set(1, 1, 5, 1, 0, 32'h80FF_1234, 3'b000, 2'd3);
    cyc();
    chk("lb_we", 32'(rw), 32'd1);
    chk("lb_id", 32'(rw_id), 32'd5);
    chk("lb_data", rw_data, 32'hFFFF_FF80);
    pipe_set(1, 1, 5, 1, 0, 32'h80FF_1234, 3'b100, 2'd3);
    cyc();
    chk("lbu_data", rw_data, 32'h0000_0080);
    pipe_set(1, 1, 5, 1, 0, 32'h8001_7FFF, 3'b001, 2'd2);
    cyc();
    chk("lh_data", rw_data, 32'hFFFF_8001);
    pipe_set(1, 1, 5, 1, 0, 32'h8001_7FFF, 3'b101, 2'd2);
    cyc();
    chk("lhu_data", rw_data, 32'h0000_8001);
    pipe_set(1, 1, 5, 1, 0, 32'h8001_7FFF, 3'b001, 2'd3);
    cyc();
    chk("lh_lo3_data", rw_data, 32'hFFFF_8001);
    pipe_set(1, 1, 5, 1, 0, 32'h8001_7FFF, 3'b011, 2'd1);
    cyc();
    chk("lw_data", rw_data, 32'h8001_7FFF);
    pipe_set(1, 1, 6, 0, 32'h1234_5678, 32'h8001_7FFF, 3'b000, 2'd0);
    cyc();
    chk("alu_id", 32'(rw_id), 32'd6);
    chk("alu_data", rw_data, 32'h1234_5678);
    pipe_set(0, 0, 0, 0, 0, 0, 3'b000, 2'd0);
    cyc();
    chk("idle_we", 32'(rw), 32'd0);
    chk("idle_hold", rw_data, 32'h1234_5678);

    // Long-latency result with idle pipeline: push edge, then pop edge
    lu_push(5'd7, 32'hDEAD_BEEF, n);
    chk("lu_not_yet", 32'(rw), 32'd0);
    cyc();
    chk("lu_we", 32'(rw), 32'd1);
    chk("lu_id", 32'(rw_id), 32'd7);
    chk("lu_data", rw_data, 32'hDEAD_BEEF);

    // Starvation: pipeline writes every cycle, one FIFO entry
    pipe_set(1, 1, 3, 0, 32'h0000_0300, 0, 3'b000, 2'd0);
    lu_push(5'd9, 32'h0000_9999, n);
    cyc();
    cyc();
    cyc();
    chk("starve_early", 32'(starve), 32'd0);
    cyc();
    chk("starve_set", 32'(starve), 32'd1);
    chk("starve_mem_ready", 32'(mem_ready), 32'd0);
    cyc();
    chk("starve_pop_id", 32'(rw_id), 32'd9);
    chk("starve_pop_data", rw_data, 32'h0000_9999);
    chk("starve_clear", 32'(starve), 32'd0);
    cyc();
    chk("resume_id", 32'(rw_id), 32'd3);

    // Fill FIFO with the pipeline busy; third push waits for a forced drain
    lu_push(5'd10, 32'h0000_0010, n);
    lu_push(5'd11, 32'h0000_0011, n);
    chk("fifo_full", 32'(lu_ready), 32'd0);
    lu_push(5'd12, 32'h0000_0012, n);
    chk("third_push_wait", 32'(n), 32'd5);
    pipe_set(0, 0, 0, 0, 0, 0, 3'b000, 2'd0);
    cyc();
    chk("drain_id11", 32'(rw_id), 32'd11);
    cyc();
    chk("drain_id12", 32'(rw_id), 32'd12);

    // Discarded FIFO entry and pipeline write to r0
    lu_push(5'd0, 32'h0000_0055, n);
    cyc();
    chk("lu_dst0_we", 32'(rw), 32'd0);
    pipe_set(1, 1, 0, 0, 32'h0000_AAAA, 0, 3'b000, 2'd0);
    cyc();
    chk("pipe_dst0_we", 32'(rw), 32'd0);
    chk("pipe_dst0_hold", rw_data, 32'h0000_0012);

    // Stall for 3 cycles mid-stream; lu push still accepted
    pipe_set(1, 1, 4, 0, 32'h0000_4444, 0, 3'b000, 2'd0);
    cyc();
    chk("pre_stall_data", rw_data, 32'h0000_4444);
    is_stalling = 1'b1;
    pipe_set(1, 1, 8, 0, 32'h0000_8888, 0, 3'b000, 2'd0);
    lu_valid = 1'b1;
    lu_dst   = 5'd13;
    lu_data  = 32'h0000_1313;
    for (int i = 0; i < 3; i++) begin
      cyc();
      lu_valid = 1'b0;
      chk("stall_we", 32'(rw), 32'd1);
      chk("stall_data", rw_data, 32'h0000_4444);
      chk("stall_mem_ready", 32'(mem_ready), 32'd0);
    end
    is_stalling = 1'b0;
    cyc();
    chk("post_stall_data", rw_data, 32'h0000_8888);
    pipe_set(0, 0, 0, 0, 0, 0, 3'b000, 2'd0);
    cyc();
    chk("stall_push_id", 32'(rw_id), 32'd13);

    // Reset mid-drain discards FIFO contents
    pipe_set(1, 1, 3, 0, 32'h0000_0333, 0, 3'b000, 2'd0);
    lu_push(5'd20, 32'h0000_0020, n);
    lu_push(5'd21, 32'h0000_0021, n);
    rst_n = 1'b0;
    cyc();
    chk("mid_rst_we", 32'(rw), 32'd0);
    chk("mid_rst_id", 32'(rw_id), 32'd0);
    chk("mid_rst_data", rw_data, 32'd0);
    chk("mid_rst_lu_ready", 32'(lu_ready), 32'd1);
    rst_n = 1'b1;
    pipe_set(0, 0, 0, 0, 0, 0, 3'b000, 2'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post_rst_no_write", 32'(rw), 32'd0);
    end
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
